// File: rtl/block_serializer.sv
// rtl/block_serializer.sv - IN_W-to-OUT_W block serializer with valid/ready on both sides.
// Optional macro SERIALIZER_DOUBLE_BUF_EN adds a holding register for bubble-free back-to-back blocks.
module block_serializer #(
  parameter int IN_W      = 128,
  parameter int OUT_W     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_last_o,
  output logic             busy_o
);

  localparam int NWORDS = IN_W / OUT_W;
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  if ((OUT_W <= 0) || (IN_W % OUT_W != 0)) begin : g_bad_width
    $error("block_serializer: IN_W must be a positive multiple of OUT_W");
  end

  logic [0:0]      state_q, state_d;
  logic [IN_W-1:0] shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hold_full;
  logic [IN_W-1:0] shifted;
  logic [OUT_W-1:0] head_word;
  logic            accept;
  logic            out_hs;
  logic            last_word;

`ifdef SERIALIZER_DOUBLE_BUF_EN
  logic [IN_W-1:0] hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  assign hold_full  = hold_full_q;
  assign in_ready_o = !reset && !hold_full_q && !flush_i;
`else
  assign hold_full  = 1'b0;
  assign in_ready_o = !reset && (state_q == ST_IDLE) && !flush_i;
`endif

  // Shift toward the output end so the next word is always at the same slice.
  assign shifted   = MSB_FIRST ? (shift_q << OUT_W) : (shift_q >> OUT_W);
  assign head_word = MSB_FIRST ? shift_q[IN_W-1 -: OUT_W] : shift_q[OUT_W-1:0];

  assign out_valid_o = (state_q == ST_SHIFT);
  assign out_data_o  = out_valid_o ? head_word : '0;
  assign last_word   = (cnt_q == LAST_CNT);
  assign out_last_o  = out_valid_o && last_word;
  assign busy_o      = (state_q == ST_SHIFT) || hold_full;

  assign accept = in_valid_i && in_ready_o;
  assign out_hs = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef SERIALIZER_DOUBLE_BUF_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    if (flush_i) begin
      state_d = ST_IDLE;
      shift_d = '0;
      cnt_d   = '0;
`ifdef SERIALIZER_DOUBLE_BUF_EN
      hold_d      = '0;
      hold_full_d = 1'b0;
`endif
    end else if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d = ST_SHIFT;
        shift_d = in_data_i;
        cnt_d   = '0;
      end
    end else if (out_hs && last_word) begin
`ifdef SERIALIZER_DOUBLE_BUF_EN
      // A fresh block arriving on the final handshake bypasses the hold register.
      if (accept) begin
        shift_d = in_data_i;
        cnt_d   = '0;
      end else if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
        cnt_d       = '0;
      end else begin
        state_d = ST_IDLE;
        shift_d = shifted;
        cnt_d   = '0;
      end
`else
      state_d = ST_IDLE;
      shift_d = shifted;
      cnt_d   = '0;
`endif
    end else begin
      if (out_hs) begin
        shift_d = shifted;
        cnt_d   = cnt_q + CW'(1);
      end
`ifdef SERIALIZER_DOUBLE_BUF_EN
      if (accept) begin
        hold_d      = in_data_i;
        hold_full_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIALIZER_DOUBLE_BUF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

endmodule

// File: tb/tb_block_serializer.sv
// tb/tb_block_serializer.sv - self-checking bench for block_serializer (MSB- and LSB-first instances).
module tb_block_serializer;

  localparam int IN_W  = 128;
  localparam int OUT_W = 32;
  localparam int NW    = IN_W / OUT_W;
`ifdef SERIALIZER_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [IN_W-1:0] in_data = '0;

  logic m_ready, m_valid, m_last, m_busy;
  logic [OUT_W-1:0] m_data;
  logic l_ready, l_valid, l_last, l_busy;
  logic [OUT_W-1:0] l_data;

  always #5 clk = ~clk;

  block_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(m_ready), .in_data_i(in_data),
    .out_valid_o(m_valid), .out_ready_i(out_ready), .out_data_o(m_data),
    .out_last_o(m_last), .busy_o(m_busy)
  );

  block_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(l_ready), .in_data_i(in_data),
    .out_valid_o(l_valid), .out_ready_i(out_ready), .out_data_o(l_data),
    .out_last_o(l_last), .busy_o(l_busy)
  );

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             last;
  } word_t;

  typedef struct {
    logic             in_valid;
    logic [IN_W-1:0]  data;
    logic             exp_ready;
    logic             exp_valid;
    logic [OUT_W-1:0] exp_msb;
    logic [OUT_W-1:0] exp_lsb;
    logic             exp_last;
  } vec_t;

  // Reference: pending output words, in emission order, for each word order.
  word_t qm[$];
  word_t ql[$];
  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pend_blocks();
    return (qm.size() + NW - 1) / NW;
  endfunction

  function automatic logic model_ready();
    if (reset || flush) return 1'b0;
    return DB ? (pend_blocks() < 2) : (pend_blocks() == 0);
  endfunction

  task automatic push_block(input logic [IN_W-1:0] d);
    word_t w;
    for (int i = 0; i < NW; i++) begin
      w.last = (i == NW - 1);
      w.d = d[IN_W-1-i*OUT_W -: OUT_W];
      qm.push_back(w);
      w.d = d[i*OUT_W +: OUT_W];
      ql.push_back(w);
    end
  endtask

  task automatic drive_and_check(input logic iv, input logic [IN_W-1:0] d,
                                 input logic ordy, input logic fl);
    logic ev;
    @(negedge clk);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    #1;
    ev = (qm.size() > 0);
    chk("in_ready", m_ready, model_ready());
    chk("in_ready_lsb", l_ready, model_ready());
    chk("out_valid", m_valid, ev);
    chk("out_valid_lsb", l_valid, ev);
    chk("out_data", m_data, ev ? qm[0].d : '0);
    chk("out_data_lsb", l_data, ev ? ql[0].d : '0);
    chk("out_last", m_last, ev ? qm[0].last : 1'b0);
    chk("out_last_lsb", l_last, ev ? ql[0].last : 1'b0);
    chk("busy", m_busy, pend_blocks() > 0);
  endtask

  task automatic advance();
    logic acc;
    acc = in_valid && model_ready();
    @(posedge clk);
    if (flush) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0 && out_ready) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) push_block(in_data);
    end
  endtask

  task automatic step(input logic iv, input logic [IN_W-1:0] d, input logic ordy, input logic fl);
    drive_and_check(iv, d, ordy, fl);
    advance();
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * NW && qm.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  function automatic logic [IN_W-1:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  localparam logic [IN_W-1:0] DATA1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, DATA1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[1] = '{1'b0, '0, DB, 1'b1, 32'h00112233, 32'hCCDDEEFF, 1'b0};
    tbl[2] = '{1'b0, '0, DB, 1'b1, 32'h44556677, 32'h8899AABB, 1'b0};
    tbl[3] = '{1'b0, '0, DB, 1'b1, 32'h8899AABB, 32'h44556677, 1'b0};
    tbl[4] = '{1'b0, '0, DB, 1'b1, 32'hCCDDEEFF, 32'h00112233, 1'b1};
    tbl[5] = '{1'b0, '0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};

    // Reset state
    #12;
    chk("rst_out_valid", m_valid, 1'b0);
    chk("rst_out_data", m_data, '0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_in_ready", m_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, '0, 1'b1, 1'b0);

    // Single block, both word orders, out_ready held high
    for (int i = 0; i < 6; i++) begin
      drive_and_check(tbl[i].in_valid, tbl[i].data, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_ready", i), m_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_msb", i), m_data, tbl[i].exp_msb);
      chk($sformatf("tbl%0d_lsb", i), l_data, tbl[i].exp_lsb);
      chk($sformatf("tbl%0d_last", i), m_last, tbl[i].exp_last);
      advance();
    end

    // Backpressure on the second word while another block is offered
    step(1'b1, DATA1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rand_block(), 1'b0, 1'b0);
      chk("bp_hold_data", m_data, 32'h44556677);
    end
    in_valid = 1'b0;
    drain();

    // Flush while word 2 is shown, then restart from the first word
    step(1'b1, DATA1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    drive_and_check(1'b1, ~DATA1, 1'b1, 1'b0);
    chk("flush_valid", m_valid, 1'b0);
    chk("flush_busy", m_busy, 1'b0);
    chk("flush_ready", m_ready, 1'b1);
    advance();
    drive_and_check(1'b0, '0, 1'b1, 1'b0);
    chk("flush_restart", m_data, 32'hFFEEDDCC);
    advance();
    drain();

    // Asynchronous reset in the middle of a block
    step(1'b1, DATA1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", m_valid, 1'b0);
    chk("arst_data", m_data, '0);
    chk("arst_last", m_last, 1'b0);
    chk("arst_busy", m_busy, 1'b0);
    qm.delete();
    ql.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, DATA1, 1'b1, 1'b0);
    drain();

    // Two blocks offered back-to-back
    begin
      logic [IN_W-1:0] a, b;
      int sent, nvalid, first, lastc, cyc;
      a = rand_block();
      b = rand_block();
      sent = 0; nvalid = 0; first = -1; lastc = -1; cyc = 0;
      for (int i = 0; i < 30; i++) begin
        logic acc;
        drive_and_check(sent < 2, (sent == 0) ? a : b, 1'b1, 1'b0);
        if (m_valid) begin
          nvalid++;
          if (first < 0) first = cyc;
          lastc = cyc;
        end
        acc = in_valid && model_ready();
        advance();
        if (acc) sent++;
        cyc++;
        if (sent == 2 && qm.size() == 0) break;
      end
      chk("b2b_sent", sent, 2);
      chk("b2b_nvalid", nvalid, 2 * NW);
      chk("b2b_span", lastc - first + 1, DB ? 2 * NW : 2 * NW + 1);
    end

    // Randomized traffic against the reference queue
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, rand_block(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end
    drain();
    drive_and_check(1'b0, '0, 1'b1, 1'b0);
    advance();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
